// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port word memory between a read-only
// instruction-fetch port and a read/write data port. Round-robin grant,
// latched request payload, one-cycle ack pulse, and a saturating watchdog
// that ends accesses the memory never answers.
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch port
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ack,
  output logic                  i_err,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err,
  // memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_response
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

  state_e                state_q, state_d;
  port_e                 owner_q, owner_d;
  port_e                 last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_err_q, i_err_d;
  logic                  d_err_q, d_err_d;
  logic                  grant_d;

  // Strobes and acks decode straight from registered state so an
  // asynchronous reset removes them without waiting for a clock edge.
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ack     = (state_q == RESP) && (owner_q == PORT_I);
  assign d_ack     = (state_q == RESP) && (owner_q == PORT_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_err     = i_err_q;
  assign d_err     = d_err_q;

  // Next-state: arbitration in IDLE, response/watchdog in ACCESS, ack in RESP.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wdog_d       = wdog_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_err_d      = i_err_q;
    d_err_d      = d_err_q;
    grant_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          // Data wins only when fetch is absent or fetch had the last grant.
          grant_d      = d_req && (!i_req || (last_grant_q == PORT_I));
          owner_d      = grant_d ? PORT_D : PORT_I;
          last_grant_d = grant_d ? PORT_D : PORT_I;
          we_d         = grant_d ? d_we : 1'b0;
          addr_d       = grant_d ? d_addr : i_addr;
          wdata_d      = grant_d ? d_wdata : '0;
          wdog_d       = '0;
          state_d      = ACCESS;
        end
      end

      ACCESS: begin
        if (mem_response) begin
          state_d = RESP;
          if (owner_q == PORT_D) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
            d_err_d   = 1'b0;
          end else begin
            i_rdata_d = mem_rdata;
            i_err_d   = 1'b0;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d = RESP;
          if (owner_q == PORT_D) begin
            d_rdata_d = '0;
            d_err_d   = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_err_d   = 1'b1;
          end
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + WD_ONE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves last_grant at DATA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      last_grant_q <= PORT_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wdog_q       <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wdog_q       <= wdog_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_err_q      <= i_err_d;
      d_err_q      <= d_err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: transaction-level model plus directed vectors.
module tb_memory_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack, i_err;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack, d_err;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_response;
  logic          mem_responsive = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ack       (i_ack),
    .i_err       (i_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .d_err       (d_err),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_response(mem_response)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned idx);
    return (idx == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 + idx);
  endfunction

  // Memory device: answers every strobe at once when responsive.
  logic [DW-1:0] dev_mem [64];
  logic          dev_loaded = 1'b0;
  assign mem_response = mem_responsive && (mem_read || mem_write);
  assign mem_rdata    = mem_read ? dev_mem[mem_addr[7:2]] : '0;

  always @(posedge clk) begin
    if (!dev_loaded) begin
      for (int unsigned i = 0; i < 64; i++) dev_mem[i] <= init_word(i);
      dev_loaded <= 1'b1;
    end else if (mem_write && mem_response) begin
      dev_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a granted transaction occupies the memory for a known number of
  // strobe cycles (1 if responsive, TMO if not), then acks for one cycle.
  logic [DW-1:0] ref_mem [64];
  logic          ref_loaded = 1'b0;
  logic          m_resp, m_own_d, m_we, m_last_d, m_fail;
  int            m_left;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_i_rdata, m_d_rdata;
  logic          m_i_err, m_d_err;
  logic          pick_d;

  assign pick_d = d_req && (!i_req || !m_last_d);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!ref_loaded) begin
        for (int unsigned i = 0; i < 64; i++) ref_mem[i] <= init_word(i);
        ref_loaded <= 1'b1;
      end
      m_resp    <= 1'b0;
      m_own_d   <= 1'b0;
      m_we      <= 1'b0;
      m_last_d  <= 1'b1;
      m_fail    <= 1'b0;
      m_left    <= 0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_i_rdata <= '0;
      m_d_rdata <= '0;
      m_i_err   <= 1'b0;
      m_d_err   <= 1'b0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_resp <= 1'b1;
        if (!m_fail && m_we) ref_mem[m_addr[7:2]] <= m_wdata;
        if (m_own_d) begin
          m_d_rdata <= (m_fail || m_we) ? '0 : ref_mem[m_addr[7:2]];
          m_d_err   <= m_fail;
        end else begin
          m_i_rdata <= m_fail ? '0 : ref_mem[m_addr[7:2]];
          m_i_err   <= m_fail;
        end
      end
    end else if (i_req || d_req) begin
      m_own_d  <= pick_d;
      m_last_d <= pick_d;
      m_we     <= pick_d && d_we;
      m_addr   <= pick_d ? d_addr : i_addr;
      m_wdata  <= d_wdata;
      m_fail   <= !mem_responsive;
      m_left   <= mem_responsive ? 1 : TMO;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("cmp_i_ack", i_ack, m_resp && !m_own_d);
      chk1("cmp_d_ack", d_ack, m_resp && m_own_d);
      chk1("cmp_mem_read", mem_read, (m_left > 0) && !m_we);
      chk1("cmp_mem_write", mem_write, (m_left > 0) && m_we);
      if (m_left > 0) chk32("cmp_mem_addr", mem_addr, m_addr);
      if ((m_left > 0) && m_we) chk32("cmp_mem_wdata", mem_wdata, m_wdata);
      chk32("cmp_i_rdata", i_rdata, m_i_rdata);
      chk32("cmp_d_rdata", d_rdata, m_d_rdata);
      chk1("cmp_i_err", i_err, m_i_err);
      chk1("cmp_d_err", d_err, m_d_err);
    end
  end

  // Waits for an ack on one port; k is the number of negedges it took.
  task automatic wait_ack(input bit port_d, input int budget, output int k);
    logic seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      seen = port_d ? d_ack : i_ack;
    end
    if (!seen) chk1(port_d ? "d_ack_wait" : "i_ack_wait", seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int nr;
    int ack_k[$];
    bit ack_d[$];
    int both;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_i_rdata", i_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_i_err", i_err, 1'b0);
    chk1("rst_d_err", d_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch of word 4
    i_req = 1'b1; i_addr = 32'h10;
    chk1("t1_c0_mem_read", mem_read, 1'b0);
    @(negedge clk);
    chk1("t1_c1_mem_read", mem_read, 1'b1);
    chk32("t1_c1_mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk1("t1_c2_i_ack", i_ack, 1'b1);
    chk32("t1_c2_i_rdata", i_rdata, 32'hDEAD_BEEF);
    chk1("t1_c2_i_err", i_err, 1'b0);
    chk1("t1_c2_mem_read", mem_read, 1'b0);
    chk1("t1_c2_d_ack", d_ack, 1'b0);
    @(negedge clk);
    i_req = 1'b0;

    // Data write then readback
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk1("t2_mem_write", mem_write, 1'b1);
    chk32("t2_mem_addr", mem_addr, 32'h20);
    chk32("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    chk1("t2_d_ack", d_ack, 1'b1);
    chk32("t2_d_rdata", d_rdata, 32'h0);
    chk1("t2_mem_write_off", mem_write, 1'b0);
    @(negedge clk);
    d_we = 1'b0;
    wait_ack(1'b1, 8, k);
    chk32("t2_read_latency", k, 2);
    chk32("t2_read_data", d_rdata, 32'h1234_5678);
    @(negedge clk);
    d_req = 1'b0;

    // Fairness with both requests held from reset
    rst = 1'b1;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    rst = 1'b0;
    both = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) both++;
      if (i_ack || d_ack) begin
        ack_k.push_back(c);
        ack_d.push_back(d_ack);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk32("t3_ack_count", ack_k.size(), 4);
    chk32("t3_both_acks", both, 0);
    for (int i = 0; i < 4; i++) begin
      chk32("t3_ack_cycle", (i < ack_k.size()) ? ack_k[i] : -1, 2 + 3 * i);
      chk1("t3_ack_is_data", (i < ack_d.size()) ? ack_d[i] : 1'bx, i[0]);
    end

    // Watchdog timeout on a silent memory
    @(negedge clk);
    mem_responsive = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    k = 0; nr = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_read) nr++;
    end while (!d_ack && k < 12);
    chk1("t4_d_ack", d_ack, 1'b1);
    chk32("t4_read_cycles", nr, 4);
    chk32("t4_ack_cycle", k, 5);
    chk1("t4_d_err", d_err, 1'b1);
    chk32("t4_d_rdata", d_rdata, 32'h0);
    @(negedge clk);
    mem_responsive = 1'b1;
    wait_ack(1'b1, 8, k);
    chk32("t4_retry_latency", k, 2);
    chk1("t4_retry_err", d_err, 1'b0);
    chk32("t4_retry_rdata", d_rdata, 32'h1234_5678);
    @(negedge clk);
    d_req = 1'b0;

    // Reset during a write access
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk1("t5_mem_write_before", mem_write, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("t5_async_drop", mem_write, 1'b0);
    chk32("t5_async_addr", mem_addr, 32'h0);
    @(negedge clk);
    chk1("t5_no_ack_a", d_ack, 1'b0);
    @(negedge clk);
    chk1("t5_no_ack_b", d_ack, 1'b0);
    rst = 1'b0;
    wait_ack(1'b1, 8, k);
    chk32("t5_after_rst_latency", k, 2);
    chk1("t5_d_err", d_err, 1'b0);
    @(negedge clk);
    d_we = 1'b0;
    wait_ack(1'b1, 8, k);
    chk32("t5_readback", d_rdata, 32'hA5A5_A5A5);
    @(negedge clk);
    d_req = 1'b0;

    // Fetch request held through ack: back-to-back fetches
    i_req = 1'b1; i_addr = 32'h10;
    wait_ack(1'b0, 8, k);
    chk32("t6_first_latency", k, 2);
    chk1("t6_resp1_mem_read", mem_read, 1'b0);
    @(negedge clk);
    chk1("t6_idle_mem_read", mem_read, 1'b0);
    chk1("t6_idle_i_ack", i_ack, 1'b0);
    @(negedge clk);
    chk1("t6_access2_mem_read", mem_read, 1'b1);
    @(negedge clk);
    chk1("t6_resp2_i_ack", i_ack, 1'b1);
    chk1("t6_resp2_mem_read", mem_read, 1'b0);
    chk32("t6_resp2_i_rdata", i_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    i_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-port arbiter/sequencer that shares one single-port word memory between the instruction-fetch port (read-only) and the data port (read/write).
- Sits between the core's fetch and load/store units and the memory's read/write/address/write-data/read-data/response interface.
- Round-robin fair grant, registered request capture, one-cycle acknowledge pulse, and a watchdog that terminates accesses the memory never answers.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT_CYCLES, 16, max ACCESS cycles without mem_response before error termination (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_WIDTH  fetch byte address.
- i_rdata  out  DATA_WIDTH  fetch read data; valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse, fetch port.
- i_err  out  1  timeout flag; qualified by i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data.
- d_rdata  out  DATA_WIDTH  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse, data port.
- d_err  out  1  timeout flag; qualified by d_ack.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; combinational, valid while mem_read=1.
- mem_response  in  1  memory completion, sampled in ACCESS.

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - All acks, errs, mem_read, mem_write = 0.
  - i_rdata, d_rdata, mem_addr, mem_wdata = 0.
  - last_grant = DATA, so the first tie goes to fetch.
  - Watchdog counter = 0.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - Requests are sampled only in this state.
  - Only one request: grant it.
  - Both requests: grant the port not equal to last_grant.
  - On grant: latch addr/we/wdata (fetch forces we=0), set owner and last_grant, clear watchdog, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_read = !we_latched and mem_write = we_latched, asserted for exactly this state. mem_addr and mem_wdata come from the latches and are stable throughout.
  - mem_response=1: capture mem_rdata into the owner's rdata register (writes load 0), err=0, go to RESP.
  - Otherwise increment the watchdog. At TIMEOUT_CYCLES-1 without a response: rdata=0, err=1, go to RESP.
  - The write commits at the clock edge ending the ACCESS cycle; exactly one write strobe cycle per transaction.
- RESP:
  - Owner's ack=1 for one cycle; the other port's ack stays 0.
  - Strobes are 0; requests are ignored.
  - Always returns to IDLE.
- Latency with a memory that responds immediately:
  - Cycle 0: req seen in IDLE.
  - Cycle 1: ACCESS.
  - Cycle 2: ack.
  - Throughput is one transaction per 3 cycles.
- Handshake:
  - Requester keeps req and its payload stable from assertion until the ack cycle inclusive.
  - Req still high in the IDLE cycle after ack counts as a new request.
  - Dropping req before ack is illegal; behaviour is undefined, but the FSM must still complete and return to IDLE.
- rdata/err registers hold their value between acks and change only when entering RESP for that port.
- Fairness: with both requests continuously asserted, grants alternate I, D, I, D…; neither port waits more than one other transaction.
- The watchdog saturates and never wraps. Watchdog width = clog2(TIMEOUT_CYCLES)+1.
- Reset asserted mid-ACCESS drops strobes immediately (asynchronously) and aborts with no ack. After reset release, pending requests re-arbitrate from IDLE with last_grant=DATA.
- Address bits [1:0] pass through unchanged; the memory ignores them.

Test Plan:
- Reset, then i_req=1, i_addr=0x10, memory word 4 = 0xDEADBEEF -> mem_read high exactly in cycle 1; i_ack=1, i_rdata=0xDEADBEEF, i_err=0 in cycle 2.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> one mem_write cycle with mem_addr=0x20; d_ack next cycle, d_rdata=0. A later data read of 0x20 returns 0x12345678.
- i_req and d_req both held high from reset for 12 cycles -> ack order I, D, I, D; each ack 3 cycles apart; i_ack and d_ack never asserted together.
- mem_response tied 0, TIMEOUT_CYCLES=4, d_req read -> mem_read high for 4 cycles, then d_ack=1, d_err=1, d_rdata=0; the next transaction with a responsive memory reports err=0.
- rst pulsed during ACCESS of a data write -> mem_write falls with rst (no clock needed), no d_ack; after release, the held d_req completes normally in 3 cycles.
- i_req held high through i_ack -> a second fetch grants in the IDLE cycle after ack; mem_read is 0 during both RESP cycles.
